alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that runs one shared 1-bit ALU slice over WIDTH cycles to perform WIDTH-bit add, unsigned compare and bitwise AND. It takes the place of a WIDTH-slice ripple ALU wherever area matters more than latency. It accepts one operation per start pulse, feeds operand bits LSB-first through the slice, and holds the carry and compare state between cycles. It reports the result with a single-cycle done pulse.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_bit_slice.sv | 35 +++
 rtl/alu_serial_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_serial_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state type for the bit-serial ALU
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice shared across all bit positions
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [1:0] op,
    output logic       f,
    output logic       c_o,
    output logic       bit_gt,
    output logic       bit_lt
);

    always_comb begin
        f   = 1'b0;
        c_o = 1'b0;
        case (op)
            OP_ADD: begin
                f   = a_i ^ b_i ^ c_i;
                c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
            end
            OP_AND: f = a_i & b_i;
            default: begin
                f   = 1'b0;
                c_o = 1'b0;
            end
        endcase
    end

    // Per-bit ordering; the controller only folds these in for CMP.
    assign bit_gt = a_i & ~b_i;
    assign bit_lt = ~a_i & b_i;

endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - sequencer running one ALU slice over WIDTH cycles, LSB first
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             neg,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             gt_q;
    logic             lt_q;

    logic             f;
    logic             c_o;
    logic             bit_gt;
    logic             bit_lt;
    logic [WIDTH-1:0] res_next;
    logic             gt_next;
    logic             lt_next;

    alu_bit_slice u_slice (
        .a_i    (a_sr[0]),
        .b_i    (b_sr[0]),
        .c_i    (carry_q),
        .op     (op_q),
        .f      (f),
        .c_o    (c_o),
        .bit_gt (bit_gt),
        .bit_lt (bit_lt)
    );

    // Next-state values are shared by the shift step and the final capture into the outputs.
    always_comb begin
        res_next = {f, res_sr[WIDTH-1:1]};
        gt_next  = gt_q;
        lt_next  = lt_q;
        if (op_q == OP_CMP && (bit_gt | bit_lt)) begin
            gt_next = bit_gt;
            lt_next = bit_lt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt     <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            neg     <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        op_q    <= op;
                        res_sr  <= '0;
                        carry_q <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry_q <= (op_q == OP_ADD) ? c_o : 1'b0;
                    gt_q    <= gt_next;
                    lt_q    <= lt_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= res_next;
                        cout   <= (op_q == OP_ADD) & c_o;
                        neg    <= (op_q == OP_ADD) & res_next[WIDTH-1];
                        gt     <= (op_q == OP_CMP) & gt_next;
                        lt     <= (op_q == OP_CMP) & lt_next;
                        eq     <= (op_q == OP_CMP) & ~gt_next & ~lt_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - directed table-driven bench for alu_serial_ctrl at WIDTH=4
module tb_alu_serial_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         neg;
        logic         eq;
        logic         gt;
        logic         lt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         neg;
    logic         eq;
    logic         gt;
    logic         lt;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[12];
    vec_t prev;
    vec_t zero_v;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .eq     (eq),
        .gt     (gt),
        .lt     (lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, "_result"}, 32'(result), 32'(v.res));
        check({tag, "_cout"},   32'(cout),   32'(v.cout));
        check({tag, "_neg"},    32'(neg),    32'(v.neg));
        check({tag, "_eq"},     32'(eq),     32'(v.eq));
        check({tag, "_gt"},     32'(gt),     32'(v.gt));
        check({tag, "_lt"},     32'(lt),     32'(v.lt));
    endtask

    // Start at a negedge, scramble inputs after acceptance, then demand exact latency.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        check("pre_busy", 32'(busy), 32'(0));
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(1));
            check("done", 32'(done), 32'(k == W + 1));
            if (k <= W) check("hold_result", 32'(result), 32'(prev.res));
        end
        check_outs("op", v);
        prev = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        //          op     a        b        res      cout  neg   eq    gt    lt
        vecs[0]  = '{2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 4'b1010, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 4'b1011, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 4'b1001, 4'b0110, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 4'b1111, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b01, 4'b1000, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        zero_v   = '{2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        prev     = zero_v;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: everything quiet for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_done", 32'(done), 32'(0));
        end
        check_outs("reset", zero_v);

        // Table, back-to-back: each start lands in the cycle right after done.
        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // start held high with changing operands: only the first op is accepted.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 4'b0111; b = 4'b0001;
        @(posedge clk);
        #1 op = 2'b11; a = 4'b1111; b = 4'b1111;
        dones = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (done) dones++;
            check("held_busy", 32'(busy), 32'(1));
        end
        start = 1'b0;
        check("held_dones", 32'(dones), 32'(1));
        check_outs("held", vecs[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_done", 32'(done), 32'(0));
            check("after_busy", 32'(busy), 32'(0));
            check("after_hold", 32'(result), 32'(4'b1000));
        end
        prev = vecs[0];

        // Reset asserted during RUN cycle E+2: operation lost, outputs cleared.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 4'b1111; b = 4'b0001;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check_outs("rst", zero_v);
        dones = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'(0));
        prev = zero_v;
        run_op(vecs[7]);
        run_op(vecs[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
